// File: rtl/evr_pkg.sv
// evr_pkg: shared types and constants for the EVR receive decoder.
// Holds the link FSM state enum, the 8b/10b K28.5 comma value and the
// reserved event codes used by the decoder and the optional timestamp block.
package evr_pkg;

  typedef enum logic [1:0] {
    ST_LOS    = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } evr_state_t;

  localparam logic [7:0] K28_5         = 8'hBC;
  localparam logic [7:0] EVT_NULL      = 8'h00;
  localparam logic [7:0] EVT_SEC0      = 8'h70;
  localparam logic [7:0] EVT_SEC1      = 8'h71;
  localparam logic [7:0] EVT_SEC_LATCH = 8'h7D;

  // One received word after the input register stage.
  typedef struct packed {
    logic [15:0] data;     // [7:0] event byte, [15:8] distributed-bus byte
    logic [1:0]  k;        // char-is-K per byte
    logic        err;      // disparity or not-in-table on either byte
    logic        link_ok;  // transceiver reset done and byte aligned
  } rx_word_t;

  // A comma is a clean K28.5 in the event byte position.
  function automatic logic is_comma(input rx_word_t w);
    return w.k[0] && (w.data[7:0] == K28_5) && !w.err;
  endfunction

endpackage

// File: rtl/evr_timestamp.sv
// evr_timestamp: seconds shift register and tick counter driven by the
// decoded event stream. Only compiled when EVR_TIMESTAMP_EN is defined.
// Events 0x70/0x71 shift a 0/1 into the seconds register MSB first; 0x7D
// publishes it and restarts the tick counter, which otherwise counts every
// locked cycle.
`ifdef EVR_TIMESTAMP_EN
module evr_timestamp
  import evr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        evt_valid,
  input  logic [7:0]  evt_code,
  input  logic        locked,
  output logic [31:0] ts_sec,
  output logic [31:0] ts_tick
);

  logic [31:0] sec_sr;

  // Shift seconds bits in, latch on 0x7D, otherwise tick while locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_sr  <= '0;
      ts_sec  <= '0;
      ts_tick <= '0;
    end else begin
      if (evt_valid && evt_code == EVT_SEC0) sec_sr <= {sec_sr[30:0], 1'b0};
      if (evt_valid && evt_code == EVT_SEC1) sec_sr <= {sec_sr[30:0], 1'b1};
      if (evt_valid && evt_code == EVT_SEC_LATCH) begin
        ts_sec  <= sec_sr;
        ts_tick <= '0;
      end else if (locked) begin
        ts_tick <= ts_tick + 32'd1;
      end
    end
  end

endmodule
`endif

// File: rtl/evr_rx_decoder.sv
// evr_rx_decoder: event-receiver word decoder behind a GT receiver.
// Stage 1 registers the raw transceiver word; stage 2 runs the link FSM
// (LOS -> ACQ -> LOCKED) and registers the event, dbus, error-count and
// link outputs, so every output lags its input word by exactly two cycles.
// Optional feature macro: EVR_TIMESTAMP_EN adds ts_sec_out/ts_tick_out and
// the evr_timestamp sub-module.
module evr_rx_decoder
  import evr_pkg::*;
#(
  parameter int LOCK_COMMAS = 16,
  parameter int ERR_THRESH  = 4
) (
  input  logic        rxusrclk2_in,
  input  logic        rx_rst_n_in,
  input  logic        rx_reset_done_in,
  input  logic        rxbyteisaligned_in,
  input  logic [15:0] rxdata_in,
  input  logic [1:0]  rxctrl0_in,
  input  logic [1:0]  rxctrl1_in,
  input  logic [1:0]  rxctrl3_in,
  output logic        link_up_out,
  output logic        event_valid_out,
  output logic [7:0]  event_code_out,
  output logic [7:0]  dbus_out,
  output logic [15:0] err_cnt_out
`ifdef EVR_TIMESTAMP_EN
  ,
  output logic [31:0] ts_sec_out,
  output logic [31:0] ts_tick_out
`endif
);

  localparam int STAGES = 1;
  localparam int ACQ_W  = $clog2(LOCK_COMMAS + 1);
  localparam int EW     = $clog2(ERR_THRESH + 1);
  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(LOCK_COMMAS - 1);
  localparam logic [EW-1:0]    ERR_LIM  = EW'(ERR_THRESH);

  // ---------------------------------------------------------------------
  // Reset: asserted asynchronously, released on a clock edge.
  // ---------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n;

  // Two-flop release synchroniser for the active-low reset.
  always_ff @(posedge rxusrclk2_in or negedge rx_rst_n_in) begin
    if (!rx_rst_n_in) rst_sync <= '0;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------------
  // Stage 1: input register
  // ---------------------------------------------------------------------
  rx_word_t          s1;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;

  // Bit 0 is the always-present input word; higher bits mark filled stages
  // so the first cycle out of reset never decodes a stale register.
  assign vld_pipe = {vld_q, 1'b1};

  // Capture the transceiver word and its status in one flop stage.
  always_ff @(posedge rxusrclk2_in or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= '0;
      vld_q <= '0;
    end else begin
      s1.data    <= rxdata_in;
      s1.k       <= rxctrl0_in;
      s1.err     <= (|rxctrl1_in) | (|rxctrl3_in);
      s1.link_ok <= rx_reset_done_in & rxbyteisaligned_in;
      vld_q      <= vld_pipe[STAGES-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: link FSM and counters
  // ---------------------------------------------------------------------
  evr_state_t       state, state_nxt;
  logic [ACQ_W-1:0] acq_cnt;
  logic [7:0]       win_cnt;
  logic [EW-1:0]    win_err, win_err_nxt;
  logic             word_v, comma, win_wrap;
  logic             locked_word, evt_hit, dbus_hit, err_hit;

  // Word classification and the window error total including this word.
  // On the wrap word the window restarts, so its error lands in the new one.
  always_comb begin
    word_v      = vld_pipe[STAGES];
    comma       = word_v && is_comma(s1);
    win_wrap    = (win_cnt == 8'hFF);
    win_err_nxt = (win_wrap ? '0 : win_err) + EW'(s1.err);
  end

  // FSM state register.
  always_ff @(posedge rxusrclk2_in or negedge rst_n) begin
    if (!rst_n) state <= ST_LOS;
    else        state <= state_nxt;
  end

  // FSM next state: losing reset-done/alignment overrides everything.
  always_comb begin
    state_nxt = state;
    if (!word_v || !s1.link_ok) begin
      state_nxt = ST_LOS;
    end else begin
      case (state)
        ST_LOS:    state_nxt = ST_ACQ;
        ST_ACQ:    if (comma && acq_cnt == ACQ_LAST) state_nxt = ST_LOCKED;
        ST_LOCKED: if (win_err_nxt >= ERR_LIM)       state_nxt = ST_LOS;
        default:   state_nxt = ST_LOS;
      endcase
    end
  end

  // FSM outputs: which registered outputs this word updates.
  always_comb begin
    locked_word = word_v && (state == ST_LOCKED) && s1.link_ok && !s1.err;
    evt_hit     = locked_word && !s1.k[0] && (s1.data[7:0] != EVT_NULL);
    dbus_hit    = locked_word && !s1.k[1];
    err_hit     = word_v && (state != ST_LOS) && s1.err;
  end

  // Consecutive-comma counter; the comma that first sees a good link counts.
  always_ff @(posedge rxusrclk2_in or negedge rst_n) begin
    if (!rst_n)                          acq_cnt <= '0;
    else if (comma && state == ST_ACQ)   acq_cnt <= acq_cnt + ACQ_W'(1);
    else if (comma && state == ST_LOS)   acq_cnt <= ACQ_W'(1);
    else                                 acq_cnt <= '0;
  end

  // 256-word error window, live only while staying locked.
  always_ff @(posedge rxusrclk2_in or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      win_err <= '0;
    end else if (state == ST_LOCKED && state_nxt == ST_LOCKED) begin
      win_cnt <= win_cnt + 8'd1;
      win_err <= win_err_nxt;
    end else begin
      win_cnt <= '0;
      win_err <= '0;
    end
  end

  // Registered outputs; code and dbus hold between updates.
  always_ff @(posedge rxusrclk2_in or negedge rst_n) begin
    if (!rst_n) begin
      link_up_out     <= 1'b0;
      event_valid_out <= 1'b0;
      event_code_out  <= '0;
      dbus_out        <= '0;
      err_cnt_out     <= '0;
    end else begin
      link_up_out     <= (state_nxt == ST_LOCKED);
      event_valid_out <= evt_hit;
      if (evt_hit)  event_code_out <= s1.data[7:0];
      if (dbus_hit) dbus_out       <= s1.data[15:8];
      if (err_hit && err_cnt_out != 16'hFFFF) err_cnt_out <= err_cnt_out + 16'd1;
    end
  end

`ifdef EVR_TIMESTAMP_EN
  evr_timestamp u_ts (
    .clk       (rxusrclk2_in),
    .rst_n     (rst_n),
    .evt_valid (event_valid_out),
    .evt_code  (event_code_out),
    .locked    (link_up_out),
    .ts_sec    (ts_sec_out),
    .ts_tick   (ts_tick_out)
  );
`endif

endmodule
